// File: rtl/cv32e40p_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cv32e40p_pkg : writeback requester ids, request struct and helpers   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package cv32e40p_pkg;

    localparam int unsigned WB_ADDR_WIDTH = 6;
    localparam int unsigned WB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        REQ_EX  = 2'd0,
        REQ_LSU = 2'd1,
        REQ_APU = 2'd2
    } wb_requester_e;

    typedef struct packed {
        logic                     valid;
        logic [WB_ADDR_WIDTH-1:0] waddr;
        logic [WB_DATA_WIDTH-1:0] wdata;
    } wb_req_t;

    // Register 0 is hardwired: a handshake to it completes but never writes.
    function automatic logic wb_writes_rf(input logic [WB_ADDR_WIDTH-1:0] waddr);
        return waddr != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_rf_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cv32e40p_rf_wb_fifo : power-of-two FIFO buffering APU writebacks     |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module cv32e40p_rf_wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned   PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = wdata_i;
            wr_ptr_d                   = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/cv32e40p_rf_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cv32e40p_rf_wb_arbiter : EX owns write port A; LSU and buffered APU  |
// | results share port B round-robin. APU path: CV32E40P_RF_WB_APU_EN.   |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
module cv32e40p_rf_wb_arbiter
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned APU_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic                  apu_valid_i,
    output logic                  apu_ready_o,
    input  logic [ADDR_WIDTH-1:0] apu_waddr_i,
    input  logic [DATA_WIDTH-1:0] apu_wdata_i,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  we_b_o,
    output logic                  apu_fifo_full_o
);

    // Requests travel as package-sized structs; keep widths within them.
    wb_req_t lsu_req;
    wb_req_t apu_req;
    wb_req_t b_req;
    logic    grant_lsu;
    logic    grant_apu;
    logic    ex_fire;

    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d;
    logic                  we_a_q,    we_a_d;
    logic [ADDR_WIDTH-1:0] waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_b_q, wdata_b_d;
    logic                  we_b_q,    we_b_d;

    assign lsu_req.valid = lsu_valid_i;
    assign lsu_req.waddr = WB_ADDR_WIDTH'(lsu_waddr_i);
    assign lsu_req.wdata = WB_DATA_WIDTH'(lsu_wdata_i);

`ifdef CV32E40P_RF_WB_APU_EN
    logic                             fifo_full;
    logic                             fifo_empty;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_rdata;
    wb_requester_e                    last_grant_q, last_grant_d;

    cv32e40p_rf_wb_fifo #(
        .DEPTH (APU_FIFO_DEPTH),
        .WIDTH (ADDR_WIDTH + DATA_WIDTH)
    ) u_apu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (apu_valid_i),
        .wdata_i ({apu_waddr_i, apu_wdata_i}),
        .pop_i   (grant_apu),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign apu_ready_o     = !fifo_full;
    assign apu_fifo_full_o = fifo_full;
    assign apu_req.valid   = !fifo_empty;
    assign apu_req.waddr   = WB_ADDR_WIDTH'(fifo_rdata[DATA_WIDTH +: ADDR_WIDTH]);
    assign apu_req.wdata   = WB_DATA_WIDTH'(fifo_rdata[DATA_WIDTH-1:0]);

    always_comb begin
        grant_lsu = lsu_req.valid;
        grant_apu = apu_req.valid;
        if (lsu_req.valid && apu_req.valid) begin
            grant_lsu = (last_grant_q != REQ_LSU);
            grant_apu = (last_grant_q == REQ_LSU);
        end
        last_grant_d = last_grant_q;
        if (grant_lsu) begin
            last_grant_d = REQ_LSU;
        end else if (grant_apu) begin
            last_grant_d = REQ_APU;
        end
    end

    // Reset to APU so the LSU takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_APU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    logic unused_apu;

    assign unused_apu      = ^{apu_valid_i, apu_waddr_i, apu_wdata_i, (APU_FIFO_DEPTH > 0)};
    assign apu_ready_o     = 1'b0;
    assign apu_fifo_full_o = 1'b0;
    assign apu_req         = '0;
    assign grant_lsu       = lsu_req.valid;
    assign grant_apu       = 1'b0;
`endif

    assign lsu_ready_o = grant_lsu;

    always_comb begin
        b_req = '0;
        if (grant_lsu) begin
            b_req = lsu_req;
        end else if (grant_apu) begin
            b_req = apu_req;
        end
    end

    // EX yields only when port B writes the same real register this cycle.
    assign ex_ready_o = !(ex_valid_i && b_req.valid &&
                          (b_req.waddr == WB_ADDR_WIDTH'(ex_waddr_i)) &&
                          wb_writes_rf(WB_ADDR_WIDTH'(ex_waddr_i)));
    assign ex_fire    = ex_valid_i && ex_ready_o;

    always_comb begin
        we_a_d    = 1'b0;
        waddr_a_d = waddr_a_q;
        wdata_a_d = wdata_a_q;
        if (ex_fire) begin
            we_a_d    = wb_writes_rf(WB_ADDR_WIDTH'(ex_waddr_i));
            waddr_a_d = ex_waddr_i;
            wdata_a_d = ex_wdata_i;
        end
        we_b_d    = 1'b0;
        waddr_b_d = waddr_b_q;
        wdata_b_d = wdata_b_q;
        if (b_req.valid) begin
            we_b_d    = wb_writes_rf(b_req.waddr);
            waddr_b_d = ADDR_WIDTH'(b_req.waddr);
            wdata_b_d = DATA_WIDTH'(b_req.wdata);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            we_a_q    <= 1'b0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
            we_b_q    <= 1'b0;
        end else begin
            waddr_a_q <= waddr_a_d;
            wdata_a_q <= wdata_a_d;
            we_a_q    <= we_a_d;
            waddr_b_q <= waddr_b_d;
            wdata_b_q <= wdata_b_d;
            we_b_q    <= we_b_d;
        end
    end

    assign waddr_a_o = waddr_a_q;
    assign wdata_a_o = wdata_a_q;
    assign we_a_o    = we_a_q;
    assign waddr_b_o = waddr_b_q;
    assign wdata_b_o = wdata_b_q;
    assign we_b_o    = we_b_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cv32e40p_rf_wb_arbiter : directed checks of the writeback arbiter |
// | Revision                  : 1.0                                      |
// +----------------------------------------------------------------------+
module tb_cv32e40p_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i, ex_ready_o;
    logic [5:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_valid_i, lsu_ready_o;
    logic [5:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        apu_valid_i, apu_ready_o;
    logic [5:0]  apu_waddr_i;
    logic [31:0] apu_wdata_i;
    logic [5:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o;
    logic        we_a_o, we_b_o, apu_fifo_full_o;

    int n_tests = 0;
    int n_fail  = 0;

    cv32e40p_rf_wb_arbiter #(
        .ADDR_WIDTH     (6),
        .DATA_WIDTH     (32),
        .APU_FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid_i      (ex_valid_i),
        .ex_ready_o      (ex_ready_o),
        .ex_waddr_i      (ex_waddr_i),
        .ex_wdata_i      (ex_wdata_i),
        .lsu_valid_i     (lsu_valid_i),
        .lsu_ready_o     (lsu_ready_o),
        .lsu_waddr_i     (lsu_waddr_i),
        .lsu_wdata_i     (lsu_wdata_i),
        .apu_valid_i     (apu_valid_i),
        .apu_ready_o     (apu_ready_o),
        .apu_waddr_i     (apu_waddr_i),
        .apu_wdata_i     (apu_wdata_i),
        .waddr_a_o       (waddr_a_o),
        .wdata_a_o       (wdata_a_o),
        .we_a_o          (we_a_o),
        .waddr_b_o       (waddr_b_o),
        .wdata_b_o       (wdata_b_o),
        .we_b_o          (we_b_o),
        .apu_fifo_full_o (apu_fifo_full_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        ex_valid_i  = 1'b0;
        lsu_valid_i = 1'b0;
        apu_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        ex_waddr_i = '0;  ex_wdata_i = '0;
        lsu_waddr_i = '0; lsu_wdata_i = '0;
        apu_waddr_i = '0; apu_wdata_i = '0;

        // Reset state
        step();
        chk("rst_we_a", we_a_o, 0);
        chk("rst_we_b", we_b_o, 0);
        chk("rst_waddr_a", waddr_a_o, 0);
        chk("rst_wdata_b", wdata_b_o, 0);
        chk("rst_full", apu_fifo_full_o, 0);
        rst_n = 1'b1;
        step();
        chk("post_rel_we_a", we_a_o, 0);
        chk("post_rel_we_b", we_b_o, 0);

        // EX write, one-cycle latency on port A
        ex_valid_i = 1'b1; ex_waddr_i = 6'd5; ex_wdata_i = 32'hDEADBEEF;
        #1 chk("ex_ready_alone", ex_ready_o, 1);
        step();
        chk("ex_we_a", we_a_o, 1);
        chk("ex_waddr_a", waddr_a_o, 5);
        chk("ex_wdata_a", wdata_a_o, 32'hDEADBEEF);
        ex_valid_i = 1'b0;
        step();
        chk("idle_we_a", we_a_o, 0);
        chk("hold_waddr_a", waddr_a_o, 5);
        chk("hold_wdata_a", wdata_a_o, 32'hDEADBEEF);

        // Collision on address 12: LSU first, EX next cycle
        ex_valid_i = 1'b1;  ex_waddr_i = 6'd12;  ex_wdata_i = 32'h1111_1111;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd12; lsu_wdata_i = 32'h2222_2222;
        #1 chk("coll_ex_ready", ex_ready_o, 0);
        chk("coll_lsu_ready", lsu_ready_o, 1);
        step();
        chk("coll_we_b", we_b_o, 1);
        chk("coll_waddr_b", waddr_b_o, 12);
        chk("coll_wdata_b", wdata_b_o, 32'h2222_2222);
        chk("coll_we_a_stall", we_a_o, 0);
        lsu_valid_i = 1'b0;
        #1 chk("coll_ex_ready_next", ex_ready_o, 1);
        step();
        chk("coll_we_a", we_a_o, 1);
        chk("coll_waddr_a", waddr_a_o, 12);
        chk("coll_wdata_a", wdata_a_o, 32'h1111_1111);
        chk("coll_we_b_idle", we_b_o, 0);
        ex_valid_i = 1'b0;

        // Address 0 never writes and never stalls EX
        ex_valid_i = 1'b1; ex_waddr_i = 6'd0; ex_wdata_i = 32'h33;
        #1 chk("zero_ex_ready", ex_ready_o, 1);
        step();
        chk("zero_we_a", we_a_o, 0);
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd0; lsu_wdata_i = 32'h44;
        #1 chk("zero_coll_ex_ready", ex_ready_o, 1);
        chk("zero_coll_lsu_ready", lsu_ready_o, 1);
        step();
        chk("zero_coll_we_a", we_a_o, 0);
        chk("zero_coll_we_b", we_b_o, 0);
        idle();

`ifndef CV32E40P_RF_WB_APU_EN
        // APU path absent: never ready, LSU always owns port B
        apu_valid_i = 1'b1; apu_waddr_i = 6'd6; apu_wdata_i = 32'h66;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd2; lsu_wdata_i = 32'h20;
        #1 chk("noapu_ready", apu_ready_o, 0);
        chk("noapu_full", apu_fifo_full_o, 0);
        chk("noapu_lsu_ready0", lsu_ready_o, 1);
        step();
        chk("noapu_waddr_b0", waddr_b_o, 2);
        #1 chk("noapu_lsu_ready1", lsu_ready_o, 1);
        step();
        chk("noapu_we_b1", we_b_o, 1);
        lsu_valid_i = 1'b0;
        step();
        chk("noapu_no_apu_wr0", we_b_o, 0);
        step();
        chk("noapu_no_apu_wr1", we_b_o, 0);
        apu_valid_i = 1'b0;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd4; lsu_wdata_i = 32'h40;
        step();
        chk("noapu_pre_rst_we_b", we_b_o, 1);
        idle();
        rst_n = 1'b0;
        #1 chk("noapu_rst_we_b", we_b_o, 0);
        chk("noapu_rst_waddr_b", waddr_b_o, 0);
        chk("noapu_rst_wdata_b", wdata_b_o, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("noapu_rel_we_b", we_b_o, 0);
`else
        // Fill two entries, then reset mid-operation (last grant is LSU here)
        apu_valid_i = 1'b1; apu_waddr_i = 6'd20; apu_wdata_i = 32'hA0;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd1;  lsu_wdata_i = 32'h100;
        #1 chk("e0_lsu_ready", lsu_ready_o, 1);
        chk("e0_apu_ready", apu_ready_o, 1);
        step();
        chk("e1_waddr_b", waddr_b_o, 1);
        apu_waddr_i = 6'd21; apu_wdata_i = 32'hA1;
        #1 chk("e1_lsu_ready", lsu_ready_o, 0);
        step();
        chk("e2_apu_lat_we_b", we_b_o, 1);
        chk("e2_apu_lat_waddr_b", waddr_b_o, 20);
        chk("e2_apu_lat_wdata_b", wdata_b_o, 32'hA0);
        apu_waddr_i = 6'd22; apu_wdata_i = 32'hA2;
        #1 chk("e2_lsu_ready", lsu_ready_o, 1);
        step();
        chk("e3_waddr_b", waddr_b_o, 1);
        idle();
        #1 chk("e3_full", apu_fifo_full_o, 1);
        chk("e3_apu_ready", apu_ready_o, 0);
        rst_n = 1'b0;
        #1 chk("rst2_we_b", we_b_o, 0);
        chk("rst2_we_a", we_a_o, 0);
        chk("rst2_waddr_b", waddr_b_o, 0);
        chk("rst2_wdata_b", wdata_b_o, 0);
        chk("rst2_full", apu_fifo_full_o, 0);
        chk("rst2_apu_ready", apu_ready_o, 1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst2_no_stale_we_b", we_b_o, 0);
        end

        // Three pushes against a busy LSU: third waits on full, order kept
        apu_valid_i = 1'b1; apu_waddr_i = 6'd10; apu_wdata_i = 32'hC0;
        #1 chk("g0_apu_ready", apu_ready_o, 1);
        step();
        chk("g1_we_b", we_b_o, 0);
        apu_waddr_i = 6'd11; apu_wdata_i = 32'hC1;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd3; lsu_wdata_i = 32'h30;
        #1 chk("g1_lsu_ready", lsu_ready_o, 1);
        chk("g1_apu_ready", apu_ready_o, 1);
        step();
        chk("g2_waddr_b", waddr_b_o, 3);
        apu_waddr_i = 6'd12; apu_wdata_i = 32'hC2;
        #1 chk("g2_third_apu_ready", apu_ready_o, 0);
        chk("g2_third_full", apu_fifo_full_o, 1);
        chk("g2_lsu_ready", lsu_ready_o, 0);
        step();
        chk("g3_we_b", we_b_o, 1);
        chk("g3_waddr_b", waddr_b_o, 10);
        chk("g3_wdata_b", wdata_b_o, 32'hC0);
        #1 chk("g3_apu_ready", apu_ready_o, 1);
        chk("g3_lsu_ready", lsu_ready_o, 1);
        step();
        chk("g4_waddr_b", waddr_b_o, 3);
        apu_valid_i = 1'b0;
        #1 chk("g4_full", apu_fifo_full_o, 1);
        chk("g4_lsu_ready", lsu_ready_o, 0);
        step();
        chk("g5_waddr_b", waddr_b_o, 11);
        chk("g5_wdata_b", wdata_b_o, 32'hC1);
        #1 chk("g5_lsu_ready", lsu_ready_o, 1);
        step();
        chk("g6_waddr_b", waddr_b_o, 3);
        lsu_valid_i = 1'b0;
        step();
        chk("g7_waddr_b", waddr_b_o, 12);
        chk("g7_wdata_b", wdata_b_o, 32'hC2);
        step();
        chk("g8_we_b", we_b_o, 0);
        chk("g8_full", apu_fifo_full_o, 0);

        // Round robin: LSU(7) and APU head(9) contend for four cycles
        apu_valid_i = 1'b1; apu_waddr_i = 6'd9; apu_wdata_i = 32'h90;
        #1 chk("f0_apu_ready", apu_ready_o, 1);
        step();
        chk("f1_we_b", we_b_o, 0);
        apu_wdata_i = 32'h91;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd7; lsu_wdata_i = 32'h70;
        #1 chk("f1_grant_lsu", lsu_ready_o, 1);
        step();
        chk("f2_waddr_b", waddr_b_o, 7);
        chk("f2_wdata_b", wdata_b_o, 32'h70);
        apu_valid_i = 1'b0; lsu_wdata_i = 32'h71;
        #1 chk("f2_grant_apu", lsu_ready_o, 0);
        chk("f2_full", apu_fifo_full_o, 1);
        step();
        chk("f3_waddr_b", waddr_b_o, 9);
        chk("f3_wdata_b", wdata_b_o, 32'h90);
        #1 chk("f3_grant_lsu", lsu_ready_o, 1);
        step();
        chk("f4_waddr_b", waddr_b_o, 7);
        chk("f4_wdata_b", wdata_b_o, 32'h71);
        lsu_wdata_i = 32'h72;
        #1 chk("f4_grant_apu", lsu_ready_o, 0);
        step();
        chk("f5_waddr_b", waddr_b_o, 9);
        chk("f5_wdata_b", wdata_b_o, 32'h91);
        #1 chk("f5_lone_lsu", lsu_ready_o, 1);
        step();
        chk("f6_we_b", we_b_o, 1);
        chk("f6_wdata_b", wdata_b_o, 32'h72);
        lsu_valid_i = 1'b0;
        step();
        chk("f7_we_b", we_b_o, 0);
        chk("f7_hold_waddr_b", waddr_b_o, 7);
        chk("f7_hold_wdata_b", wdata_b_o, 32'h72);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
